// File: rtl/ddr4_resp_pkg.sv
// Shared types for the DDR4 DRAM-side responder: command/engine enums, bank constants, command decode.
package ddr4_resp_pkg;

  localparam int unsigned NUM_BANKS    = 8;
  localparam int unsigned BANK_BITS    = 3;
  localparam int unsigned ALERT_CYCLES = 4;

  typedef enum logic [2:0] {
    CMD_MRS, CMD_REF, CMD_PRE, CMD_ACT, CMD_WR, CMD_RD, CMD_ZQ, CMD_NOP
  } cmd_e;

  typedef enum logic [1:0] {
    ENG_IDLE, ENG_WAIT_LAT, ENG_BURST
  } eng_state_e;

  // The unlisted RAS/CAS/WE code 011 is treated as a NOP.
  function automatic cmd_e decode_cmd(input logic act_n, input logic [2:0] code);
    cmd_e c;
    c = CMD_NOP;
    if (!act_n) begin
      c = CMD_ACT;
    end else begin
      case (code)
        3'b000:  c = CMD_MRS;
        3'b001:  c = CMD_REF;
        3'b010:  c = CMD_PRE;
        3'b100:  c = CMD_WR;
        3'b101:  c = CMD_RD;
        3'b110:  c = CMD_ZQ;
        default: c = CMD_NOP;
      endcase
    end
    return c;
  endfunction

endpackage

// File: rtl/ddr4_resp_bank_table.sv
// Per-bank open bitmap and open-row storage with ACT, PRE, PRE-all and auto-precharge updates.
module ddr4_resp_bank_table
  import ddr4_resp_pkg::*;
#(
  parameter int unsigned ROW_BITS = 4
) (
  input  logic                 clk_i,
  input  logic                 rst_i,
  input  logic                 act_en_i,
  input  logic [BANK_BITS-1:0] act_bank_i,
  input  logic [ROW_BITS-1:0]  act_row_i,
  input  logic                 pre_en_i,
  input  logic                 pre_all_i,
  input  logic [BANK_BITS-1:0] pre_bank_i,
  input  logic                 ap_en_i,
  input  logic [BANK_BITS-1:0] ap_bank_i,
  input  logic [BANK_BITS-1:0] lookup_bank_i,
  output logic                 lookup_open_o,
  output logic [ROW_BITS-1:0]  lookup_row_o,
  output logic [NUM_BANKS-1:0] open_o
);

  logic [NUM_BANKS-1:0] open_q, open_d;
  logic [ROW_BITS-1:0]  row_q [NUM_BANKS];

  always_comb begin
    open_d = open_q;
    if (ap_en_i) open_d[ap_bank_i] = 1'b0;
    if (pre_en_i) begin
      if (pre_all_i) open_d = '0;
      else           open_d[pre_bank_i] = 1'b0;
    end
    if (act_en_i) open_d[act_bank_i] = 1'b1;
  end

  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      open_q <= '0;
      for (int unsigned i = 0; i < NUM_BANKS; i++) row_q[i] <= '0;
    end else begin
      open_q <= open_d;
      if (act_en_i) row_q[act_bank_i] <= act_row_i;
    end
  end

  assign lookup_open_o = open_q[lookup_bank_i];
  assign lookup_row_o  = row_q[lookup_bank_i];
  assign open_o        = open_q;

endmodule

// File: rtl/ddr4_dram_responder.sv
// DDR4 DRAM-side responder: command decode, protocol checks, RD/WR burst engine and backing array.
// Optional command/address parity checking with alert is enabled by defining DDR4_RESP_PARITY_EN.
module ddr4_dram_responder
  import ddr4_resp_pkg::*;
#(
  parameter int unsigned DRAM_WIDTH   = 8,
  parameter int unsigned BURST_LENGTH = 8,
  parameter int unsigned CL           = 4,
  parameter int unsigned CWL          = 3,
  parameter int unsigned ROW_BITS     = 4,
  parameter int unsigned COL_BITS     = 6
) (
  input  logic                  clk,
  input  logic                  reset,
  input  logic                  ddr4_cke,
  input  logic                  ddr4_cs_n,
  input  logic                  ddr4_act_n,
  input  logic [15:0]           ddr4_adr,
  input  logic [1:0]            ddr4_ba,
  input  logic                  ddr4_bg,
  input  logic                  ddr4_parity,
  output logic                  ddr4_alert_n,
  input  logic [DRAM_WIDTH-1:0] dq_in,
  output logic [DRAM_WIDTH-1:0] dq_out,
  output logic                  dq_oe,
  output logic                  protocol_err,
  output logic [7:0]            err_count,
  output logic [7:0]            banks_open
);

  localparam int unsigned LAT_MAX = (CL > CWL) ? CL : CWL;
  localparam int unsigned CNT_W   = $clog2(LAT_MAX + 1);
  localparam int unsigned BEAT_W  = $clog2(BURST_LENGTH) + 1;
  localparam int unsigned AW      = BANK_BITS + ROW_BITS + COL_BITS;

  eng_state_e           state_q, state_d;
  logic [CNT_W-1:0]     cnt_q, cnt_d;
  logic [BEAT_W-1:0]    beat_q, beat_d;
  logic                 is_rd_q, ap_q;
  logic [BANK_BITS-1:0] bank_q;
  logic [ROW_BITS-1:0]  row_q;
  logic [COL_BITS-1:0]  col_q;
  logic [DRAM_WIDTH-1:0] dq_out_q;
  logic                 dq_oe_q, protocol_err_q;
  logic [7:0]           err_count_q;
  logic [DRAM_WIDTH-1:0] mem_q [2**AW];

  logic                 cmd_valid, busy, rule_err, parity_err, reject, accept, start;
  cmd_e                 cmd;
  logic [BANK_BITS-1:0] cmd_bank;
  logic                 lk_open;
  logic [ROW_BITS-1:0]  lk_row;
  logic [NUM_BANKS-1:0] open_map;
  logic                 rd_fire, wr_fire, rd_load, wr_en, rd_done, done;
  logic [BEAT_W-1:0]    beat_idx;
  logic [AW-1:0]        mem_addr;

  assign cmd_valid = ddr4_cke & ~ddr4_cs_n;
  assign cmd       = decode_cmd(ddr4_act_n, ddr4_adr[15:13]);
  assign cmd_bank  = {ddr4_bg, ddr4_ba};
  assign busy      = (state_q != ENG_IDLE);

  always_comb begin
    rule_err = 1'b0;
    case (cmd)
      CMD_ACT:        rule_err = lk_open;
      CMD_PRE:        rule_err = busy && (ddr4_adr[10] || (cmd_bank == bank_q));
      CMD_REF:        rule_err = |open_map;
      CMD_RD, CMD_WR: rule_err = !lk_open || busy;
      default:        rule_err = 1'b0;
    endcase
  end

`ifdef DDR4_RESP_PARITY_EN
  localparam int unsigned ALERT_W = $clog2(ALERT_CYCLES + 1);
  logic [ALERT_W-1:0] alert_q;

  assign parity_err = ^{ddr4_act_n, ddr4_adr, ddr4_ba, ddr4_bg, ddr4_parity};

  always_ff @(posedge clk or posedge reset) begin
    if (reset)                       alert_q <= '0;
    else if (cmd_valid & parity_err) alert_q <= ALERT_W'(ALERT_CYCLES);
    else if (alert_q != '0)          alert_q <= alert_q - ALERT_W'(1);
  end

  assign ddr4_alert_n = (alert_q == '0);
`else
  assign parity_err   = 1'b0;
  assign ddr4_alert_n = 1'b1;
`endif

  assign reject = cmd_valid & (rule_err | parity_err);
  assign accept = cmd_valid & ~reject;
  assign start  = accept & ((cmd == CMD_RD) | (cmd == CMD_WR));

  // Read data is registered, so read beats are fetched one edge ahead of the write-side timing.
  assign rd_fire  = is_rd_q & (state_q == ENG_WAIT_LAT) & (cnt_q == CNT_W'(1));
  assign wr_fire  = ~is_rd_q & (state_q == ENG_WAIT_LAT) & (cnt_q == '0);
  assign beat_idx = (state_q == ENG_WAIT_LAT) ? '0 : beat_q;
  assign mem_addr = {bank_q, row_q, col_q + COL_BITS'(beat_idx)};
  assign rd_load  = rd_fire | (is_rd_q & (state_q == ENG_BURST) & (beat_q != BEAT_W'(BURST_LENGTH)));
  assign rd_done  = is_rd_q & (state_q == ENG_BURST) & (beat_q == BEAT_W'(BURST_LENGTH));
  assign wr_en    = wr_fire | (~is_rd_q & (state_q == ENG_BURST));
  assign done     = rd_done | (wr_en & (beat_idx == BEAT_W'(BURST_LENGTH - 1)));

  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    beat_d  = beat_q;
    case (state_q)
      ENG_IDLE: begin
        if (start) begin
          state_d = ENG_WAIT_LAT;
          cnt_d   = (cmd == CMD_RD) ? CNT_W'(CL - 1) : CNT_W'(CWL - 1);
        end
      end
      ENG_WAIT_LAT: begin
        if (rd_fire || wr_fire) begin
          state_d = ENG_BURST;
          beat_d  = BEAT_W'(1);
        end else begin
          cnt_d = cnt_q - CNT_W'(1);
        end
      end
      ENG_BURST: beat_d = beat_q + BEAT_W'(1);
      default:   state_d = ENG_IDLE;
    endcase
    if (done) state_d = ENG_IDLE;
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_q        <= ENG_IDLE;
      cnt_q          <= '0;
      beat_q         <= '0;
      is_rd_q        <= 1'b0;
      ap_q           <= 1'b0;
      bank_q         <= '0;
      row_q          <= '0;
      col_q          <= '0;
      dq_out_q       <= '0;
      dq_oe_q        <= 1'b0;
      protocol_err_q <= 1'b0;
      err_count_q    <= '0;
    end else begin
      state_q        <= state_d;
      cnt_q          <= cnt_d;
      beat_q         <= beat_d;
      protocol_err_q <= reject;
      if (reject && err_count_q != 8'hFF) err_count_q <= err_count_q + 8'd1;
      if (start) begin
        is_rd_q <= (cmd == CMD_RD);
        ap_q    <= ddr4_adr[10];
        bank_q  <= cmd_bank;
        row_q   <= lk_row;
        col_q   <= ddr4_adr[COL_BITS-1:0] & ~COL_BITS'(BURST_LENGTH - 1);
      end
      if (rd_load) begin
        dq_out_q <= mem_q[mem_addr];
        dq_oe_q  <= 1'b1;
      end else if (rd_done) begin
        dq_out_q <= '0;
        dq_oe_q  <= 1'b0;
      end
    end
  end

  always_ff @(posedge clk) begin
    if (wr_en) mem_q[mem_addr] <= dq_in;
  end

  ddr4_resp_bank_table #(
    .ROW_BITS(ROW_BITS)
  ) u_bank_table (
    .clk_i        (clk),
    .rst_i        (reset),
    .act_en_i     (accept && cmd == CMD_ACT),
    .act_bank_i   (cmd_bank),
    .act_row_i    (ddr4_adr[ROW_BITS-1:0]),
    .pre_en_i     (accept && cmd == CMD_PRE),
    .pre_all_i    (ddr4_adr[10]),
    .pre_bank_i   (cmd_bank),
    .ap_en_i      (done & ap_q),
    .ap_bank_i    (bank_q),
    .lookup_bank_i(cmd_bank),
    .lookup_open_o(lk_open),
    .lookup_row_o (lk_row),
    .open_o       (open_map)
  );

  assign dq_out       = dq_out_q;
  assign dq_oe        = dq_oe_q;
  assign protocol_err = protocol_err_q;
  assign err_count    = err_count_q;
  assign banks_open   = open_map;

endmodule

// File: tb/tb_ddr4_dram_responder.sv
// Directed self-checking bench for ddr4_dram_responder (default parameters, CL=4, CWL=3, BL=8).
module tb_ddr4_dram_responder;

  logic        clk = 1'b0;
  logic        reset;
  logic        ddr4_cke, ddr4_cs_n, ddr4_act_n, ddr4_bg, ddr4_parity;
  logic [15:0] ddr4_adr;
  logic [1:0]  ddr4_ba;
  logic        ddr4_alert_n;
  logic [7:0]  dq_in, dq_out;
  logic        dq_oe, protocol_err;
  logic [7:0]  err_count, banks_open;

  int checks = 0;
  int failures = 0;

  localparam logic [2:0] C_PRE = 3'b010, C_REF = 3'b001, C_WR = 3'b100, C_RD = 3'b101, C_NOP = 3'b111;

  always #5 clk = ~clk;

  ddr4_dram_responder dut (
    .clk(clk), .reset(reset), .ddr4_cke(ddr4_cke), .ddr4_cs_n(ddr4_cs_n), .ddr4_act_n(ddr4_act_n),
    .ddr4_adr(ddr4_adr), .ddr4_ba(ddr4_ba), .ddr4_bg(ddr4_bg), .ddr4_parity(ddr4_parity),
    .ddr4_alert_n(ddr4_alert_n), .dq_in(dq_in), .dq_out(dq_out), .dq_oe(dq_oe),
    .protocol_err(protocol_err), .err_count(err_count), .banks_open(banks_open)
  );

  function automatic logic [15:0] mk_adr(input logic [2:0] code, input logic ap, input logic [9:0] low);
    return {code, 2'b00, ap, low};
  endfunction

  // Drives one command slot at a negedge; it is sampled at the following posedge (cycle N).
  // Returns at the next negedge, where values of cycle N+1 are observable.
  task automatic issue(input logic an, input logic [15:0] a, input logic [2:0] b, input logic flip);
    ddr4_act_n  = an;
    ddr4_adr    = a;
    {ddr4_bg, ddr4_ba} = b;
    ddr4_parity = (^{an, a, b[1:0], b[2]}) ^ flip;
    ddr4_cs_n   = 1'b0;
    @(negedge clk);
    ddr4_cs_n   = 1'b1;
    ddr4_act_n  = 1'b1;
    ddr4_adr    = mk_adr(C_NOP, 1'b0, 10'd0);
  endtask

  task automatic tick(input int n);
    repeat (n) @(negedge clk);
  endtask

  task automatic test_reset;
    reset = 1'b1; ddr4_cke = 1'b1; ddr4_cs_n = 1'b1; ddr4_act_n = 1'b1; ddr4_adr = 16'hE000;
    ddr4_ba = 2'b00; ddr4_bg = 1'b0; ddr4_parity = 1'b0; dq_in = 8'h00;
    tick(3);
    reset = 1'b0;
    tick(1);
    checks++; if (dq_oe !== 1'b0) begin failures++; $display("FAIL reset_dq_oe got=%b exp=0", dq_oe); end
    checks++; if (dq_out !== 8'h00) begin failures++; $display("FAIL reset_dq_out got=%h exp=00", dq_out); end
    checks++; if (protocol_err !== 1'b0) begin failures++; $display("FAIL reset_perr got=%b exp=0", protocol_err); end
    checks++; if (err_count !== 8'd0) begin failures++; $display("FAIL reset_errcnt got=%0d exp=0", err_count); end
    checks++; if (banks_open !== 8'h00) begin failures++; $display("FAIL reset_banks got=%h exp=00", banks_open); end
    checks++; if (ddr4_alert_n !== 1'b1) begin failures++; $display("FAIL reset_alert got=%b exp=1", ddr4_alert_n); end
  endtask

  task automatic test_write_read;
    logic       exp_oe;
    logic [7:0] exp_dq;
    issue(1'b0, 16'd3, 3'd0, 1'b0);
    checks++; if (banks_open !== 8'h01) begin failures++; $display("FAIL act_b0_banks got=%h exp=01", banks_open); end
    issue(1'b1, mk_adr(C_WR, 1'b0, 10'h008), 3'd0, 1'b0);
    tick(2);
    for (int k = 0; k < 8; k++) begin
      dq_in = 8'h10 + 8'(k);
      @(negedge clk);
    end
    dq_in = 8'hAA;
    issue(1'b1, mk_adr(C_RD, 1'b0, 10'h008), 3'd0, 1'b0);
    checks++; if (protocol_err !== 1'b0) begin failures++; $display("FAIL rd_after_wr_perr got=%b exp=0", protocol_err); end
    for (int j = 1; j <= 12; j++) begin
      exp_oe = (j >= 4 && j <= 11);
      exp_dq = exp_oe ? 8'h10 + 8'(j - 4) : 8'h00;
      checks++;
      if (dq_oe !== exp_oe || dq_out !== exp_dq) begin
        failures++;
        $display("FAIL rd_beat_N+%0d got oe=%b dq=%h exp oe=%b dq=%h", j, dq_oe, dq_out, exp_oe, exp_dq);
      end
      @(negedge clk);
    end
  endtask

  task automatic test_rd_closed;
    issue(1'b1, mk_adr(C_RD, 1'b0, 10'h000), 3'd5, 1'b0);
    checks++; if (protocol_err !== 1'b1) begin failures++; $display("FAIL rd_closed_perr got=%b exp=1", protocol_err); end
    checks++; if (err_count !== 8'd1) begin failures++; $display("FAIL rd_closed_errcnt got=%0d exp=1", err_count); end
    tick(1);
    checks++; if (protocol_err !== 1'b0) begin failures++; $display("FAIL rd_closed_pulse got=%b exp=0", protocol_err); end
    for (int j = 0; j < 12; j++) begin
      checks++; if (dq_oe !== 1'b0) begin failures++; $display("FAIL rd_closed_oe cyc=%0d got=%b exp=0", j, dq_oe); end
      @(negedge clk);
    end
  endtask

  task automatic test_act_pre_ref;
    issue(1'b0, 16'd7, 3'd2, 1'b0);
    checks++; if (banks_open !== 8'h05) begin failures++; $display("FAIL act_b2_banks got=%h exp=05", banks_open); end
    issue(1'b0, 16'd9, 3'd2, 1'b0);
    checks++; if (protocol_err !== 1'b1 || err_count !== 8'd2) begin failures++; $display("FAIL act_twice got perr=%b cnt=%0d exp perr=1 cnt=2", protocol_err, err_count); end
    issue(1'b1, mk_adr(C_PRE, 1'b1, 10'h000), 3'd0, 1'b0);
    checks++; if (banks_open !== 8'h00) begin failures++; $display("FAIL pre_all_banks got=%h exp=00", banks_open); end
    issue(1'b1, mk_adr(C_REF, 1'b0, 10'h000), 3'd0, 1'b0);
    checks++; if (protocol_err !== 1'b0 || err_count !== 8'd2) begin failures++; $display("FAIL ref_closed got perr=%b cnt=%0d exp perr=0 cnt=2", protocol_err, err_count); end
  endtask

  task automatic test_auto_precharge;
    issue(1'b0, 16'd2, 3'd1, 1'b0);
    issue(1'b1, mk_adr(C_RD, 1'b1, 10'h010), 3'd1, 1'b0);
    tick(10);
    checks++; if (banks_open !== 8'h02 || dq_oe !== 1'b1) begin failures++; $display("FAIL ap_last_beat got banks=%h oe=%b exp banks=02 oe=1", banks_open, dq_oe); end
    issue(1'b0, 16'd4, 3'd1, 1'b0);
    checks++; if (protocol_err !== 1'b1 || err_count !== 8'd3) begin failures++; $display("FAIL ap_act_reject got perr=%b cnt=%0d exp perr=1 cnt=3", protocol_err, err_count); end
    checks++; if (banks_open !== 8'h00 || dq_oe !== 1'b0) begin failures++; $display("FAIL ap_cleared got banks=%h oe=%b exp banks=00 oe=0", banks_open, dq_oe); end
  endtask

  task automatic test_back_to_back_reset;
    issue(1'b0, 16'd3, 3'd0, 1'b0);
    issue(1'b1, mk_adr(C_RD, 1'b0, 10'h008), 3'd0, 1'b0);
    tick(2);
    issue(1'b1, mk_adr(C_RD, 1'b0, 10'h008), 3'd0, 1'b0);
    checks++; if (protocol_err !== 1'b1 || err_count !== 8'd4) begin failures++; $display("FAIL b2b_reject got perr=%b cnt=%0d exp perr=1 cnt=4", protocol_err, err_count); end
    checks++; if (dq_oe !== 1'b1 || dq_out !== 8'h10) begin failures++; $display("FAIL b2b_beat0 got oe=%b dq=%h exp oe=1 dq=10", dq_oe, dq_out); end
    tick(1);
    checks++; if (dq_oe !== 1'b1 || dq_out !== 8'h11) begin failures++; $display("FAIL b2b_beat1 got oe=%b dq=%h exp oe=1 dq=11", dq_oe, dq_out); end
    reset = 1'b1;
    #1;
    checks++; if (dq_oe !== 1'b0 || banks_open !== 8'h00) begin failures++; $display("FAIL midburst_reset got oe=%b banks=%h exp oe=0 banks=00", dq_oe, banks_open); end
    checks++; if (err_count !== 8'd0 || dq_out !== 8'h00) begin failures++; $display("FAIL midburst_reset_regs got cnt=%0d dq=%h exp cnt=0 dq=00", err_count, dq_out); end
    tick(2);
    reset = 1'b0;
    tick(1);
  endtask

  task automatic test_array_retained;
    issue(1'b0, 16'd3, 3'd0, 1'b0);
    issue(1'b1, mk_adr(C_RD, 1'b0, 10'h00B), 3'd0, 1'b0);
    tick(3);
    checks++; if (dq_oe !== 1'b1 || dq_out !== 8'h10) begin failures++; $display("FAIL retain_beat0 got oe=%b dq=%h exp oe=1 dq=10", dq_oe, dq_out); end
    tick(7);
    checks++; if (dq_out !== 8'h17) begin failures++; $display("FAIL retain_beat7 got dq=%h exp dq=17", dq_out); end
    tick(2);
  endtask

  task automatic test_parity;
    issue(1'b0, 16'd5, 3'd4, 1'b1);
`ifdef DDR4_RESP_PARITY_EN
    checks++; if (protocol_err !== 1'b1 || err_count !== 8'd1) begin failures++; $display("FAIL par_reject got perr=%b cnt=%0d exp perr=1 cnt=1", protocol_err, err_count); end
    checks++; if (banks_open !== 8'h01) begin failures++; $display("FAIL par_dropped got banks=%h exp=01", banks_open); end
    for (int j = 1; j <= 5; j++) begin
      checks++;
      if (ddr4_alert_n !== (j == 5)) begin failures++; $display("FAIL par_alert N+%0d got=%b exp=%b", j, ddr4_alert_n, (j == 5)); end
      @(negedge clk);
    end
`else
    checks++; if (protocol_err !== 1'b0 || err_count !== 8'd0) begin failures++; $display("FAIL par_ignored got perr=%b cnt=%0d exp perr=0 cnt=0", protocol_err, err_count); end
    checks++; if (banks_open !== 8'h11) begin failures++; $display("FAIL par_ignored_banks got=%h exp=11", banks_open); end
    for (int j = 1; j <= 5; j++) begin
      checks++; if (ddr4_alert_n !== 1'b1) begin failures++; $display("FAIL par_alert_tied N+%0d got=%b exp=1", j, ddr4_alert_n); end
      @(negedge clk);
    end
`endif
  endtask

  task automatic test_saturation;
    for (int i = 0; i < 256; i++) issue(1'b1, mk_adr(C_RD, 1'b0, 10'h000), 3'd6, 1'b0);
    checks++; if (err_count !== 8'd255) begin failures++; $display("FAIL errcnt_saturate got=%0d exp=255", err_count); end
    ddr4_cke = 1'b0;
    issue(1'b1, mk_adr(C_RD, 1'b0, 10'h000), 3'd6, 1'b0);
    checks++; if (protocol_err !== 1'b0) begin failures++; $display("FAIL cke_low_ignored got perr=%b exp=0", protocol_err); end
    ddr4_cke = 1'b1;
  endtask

  initial begin
    test_reset();
    test_write_read();
    test_rd_closed();
    test_act_pre_ref();
    test_auto_precharge();
    test_back_to_back_reset();
    test_array_retained();
    test_parity();
    test_saturation();
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
